// File: rtl/lsu_bus_if.sv
// ============================================================================
// Module   : lsu_bus_if
// Purpose  : Load/store bridge from the memory stage to an AXI4-Lite-style bus
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_bus_if #(
  parameter int ISA_WIDTH      = 32,
  parameter int MEM_MASK_WIDTH = 4,
  parameter int FUNCT3_WIDTH   = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [FUNCT3_WIDTH-1:0]   funct3,
  input  logic [1:0]                byte_off,
  input  logic [ISA_WIDTH-1:0]      mem_2_addr,
  input  logic [ISA_WIDTH-1:0]      mem_2_w,
  input  logic [MEM_MASK_WIDTH-1:0] mem_2_mask,
  input  logic                      mem_2_r_en,
  input  logic                      mem_2_w_en,
  output logic [ISA_WIDTH-1:0]      mem_2_r,
  output logic [ISA_WIDTH-1:0]      ld_data,
  output logic                      busy,
  output logic                      done,
  output logic                      bus_err,
  output logic [ISA_WIDTH-1:0]      araddr,
  output logic                      arvalid,
  input  logic                      arready,
  input  logic [ISA_WIDTH-1:0]      rdata,
  input  logic [1:0]                rresp,
  input  logic                      rvalid,
  output logic                      rready,
  output logic [ISA_WIDTH-1:0]      awaddr,
  output logic                      awvalid,
  input  logic                      awready,
  output logic [ISA_WIDTH-1:0]      wdata,
  output logic [MEM_MASK_WIDTH-1:0] wstrb,
  output logic                      wvalid,
  input  logic                      wready,
  input  logic [1:0]                bresp,
  input  logic                      bvalid,
  output logic                      bready
);

  localparam logic [FUNCT3_WIDTH-1:0] c_funct3_lb  = FUNCT3_WIDTH'(0);
  localparam logic [FUNCT3_WIDTH-1:0] c_funct3_lh  = FUNCT3_WIDTH'(1);
  localparam logic [FUNCT3_WIDTH-1:0] c_funct3_lw  = FUNCT3_WIDTH'(2);
  localparam logic [FUNCT3_WIDTH-1:0] c_funct3_lbu = FUNCT3_WIDTH'(4);
  localparam logic [FUNCT3_WIDTH-1:0] c_funct3_lhu = FUNCT3_WIDTH'(5);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;

  logic [ISA_WIDTH-1:0]        r_addr;
  logic [ISA_WIDTH-1:0]        r_wdata;
  logic [MEM_MASK_WIDTH-1:0]   r_mask;
  logic [FUNCT3_WIDTH-1:0]     r_funct3;
  logic [1:0]                  r_byte_off;
  logic                        r_aw_done;
  logic                        r_w_done;
  logic [ISA_WIDTH-1:0]        r_mem_2_r;
  logic [ISA_WIDTH-1:0]        r_ld_data;
  logic                        r_done;
  logic                        r_bus_err;

  logic                        w_aw_hs;
  logic                        w_w_hs;
  logic                        w_aw_ok;
  logic                        w_w_ok;
  logic [ISA_WIDTH-1:0]        w_shifted;
  logic [ISA_WIDTH-1:0]        w_ld_ext;

  // Bus-side valids/readies decode straight from registered state.
  assign arvalid = (r_state == RD_ADDR);
  assign rready  = (r_state == RD_DATA);
  assign awvalid = (r_state == WR_REQ) && !r_aw_done;
  assign wvalid  = (r_state == WR_REQ) && !r_w_done;
  assign bready  = (r_state == WR_RESP);
  assign busy    = (r_state != IDLE);

  assign araddr  = r_addr;
  assign awaddr  = r_addr;
  assign wdata   = r_wdata;
  assign wstrb   = r_mask;
  assign mem_2_r = r_mem_2_r;
  assign ld_data = r_ld_data;
  assign done    = r_done;
  assign bus_err = r_bus_err;

  assign w_aw_hs = awvalid && awready;
  assign w_w_hs  = wvalid && wready;
  assign w_aw_ok = r_aw_done || w_aw_hs;
  assign w_w_ok  = r_w_done || w_w_hs;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (mem_2_w_en) begin
          w_state_nxt = WR_REQ;
        end else if (mem_2_r_en) begin
          w_state_nxt = RD_ADDR;
        end
      end
      RD_ADDR: if (arready) w_state_nxt = RD_DATA;
      RD_DATA: if (rvalid)  w_state_nxt = IDLE;
      WR_REQ:  if (w_aw_ok && w_w_ok) w_state_nxt = WR_RESP;
      WR_RESP: if (bvalid)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Load alignment works on the live rdata so the result lands with done.
  always_comb begin
    w_shifted = rdata >> {r_byte_off, 3'b000};
    w_ld_ext  = '0;
    case (r_funct3)
      c_funct3_lb:  w_ld_ext = {{(ISA_WIDTH-8){w_shifted[7]}}, w_shifted[7:0]};
      c_funct3_lbu: w_ld_ext = {{(ISA_WIDTH-8){1'b0}}, w_shifted[7:0]};
      c_funct3_lh:  w_ld_ext = {{(ISA_WIDTH-16){w_shifted[15]}}, w_shifted[15:0]};
      c_funct3_lhu: w_ld_ext = {{(ISA_WIDTH-16){1'b0}}, w_shifted[15:0]};
      c_funct3_lw:  w_ld_ext = w_shifted;
      default:      w_ld_ext = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_mask     <= '0;
      r_funct3   <= '0;
      r_byte_off <= '0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_mem_2_r  <= '0;
      r_ld_data  <= '0;
      r_done     <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_bus_err <= 1'b0;

      if (r_state == IDLE) begin
        if (mem_2_w_en) begin
          r_addr  <= mem_2_addr;
          r_wdata <= mem_2_w;
          r_mask  <= mem_2_mask;
        end else if (mem_2_r_en) begin
          r_addr     <= mem_2_addr;
          r_funct3   <= funct3;
          r_byte_off <= byte_off;
        end
      end

      // Sticky flags let AW and W finish in either order.
      if (r_state == WR_REQ) begin
        if (w_aw_ok && w_w_ok) begin
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
        end else begin
          if (w_aw_hs) r_aw_done <= 1'b1;
          if (w_w_hs)  r_w_done  <= 1'b1;
        end
      end

      if (rready && rvalid) begin
        r_mem_2_r <= rdata;
        r_ld_data <= w_ld_ext;
        r_done    <= 1'b1;
        r_bus_err <= |rresp;
      end

      if (bready && bvalid) begin
        r_done    <= 1'b1;
        r_bus_err <= |bresp;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lsu_bus_if.sv
// ============================================================================
// Module   : tb_lsu_bus_if
// Purpose  : Randomised self-checking bench for lsu_bus_if
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_bus_if;

  logic        clk;
  logic        rst_n;
  logic [2:0]  funct3;
  logic [1:0]  byte_off;
  logic [31:0] mem_2_addr;
  logic [31:0] mem_2_w;
  logic [3:0]  mem_2_mask;
  logic        mem_2_r_en;
  logic        mem_2_w_en;
  logic [31:0] mem_2_r;
  logic [31:0] ld_data;
  logic        busy;
  logic        done;
  logic        bus_err;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  lsu_bus_if #(
    .ISA_WIDTH      (32),
    .MEM_MASK_WIDTH (4),
    .FUNCT3_WIDTH   (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .funct3     (funct3),
    .byte_off   (byte_off),
    .mem_2_addr (mem_2_addr),
    .mem_2_w    (mem_2_w),
    .mem_2_mask (mem_2_mask),
    .mem_2_r_en (mem_2_r_en),
    .mem_2_w_en (mem_2_w_en),
    .mem_2_r    (mem_2_r),
    .ld_data    (ld_data),
    .busy       (busy),
    .done       (done),
    .bus_err    (bus_err),
    .araddr     (araddr),
    .arvalid    (arvalid),
    .arready    (arready),
    .rdata      (rdata),
    .rresp      (rresp),
    .rvalid     (rvalid),
    .rready     (rready),
    .awaddr     (awaddr),
    .awvalid    (awvalid),
    .awready    (awready),
    .wdata      (wdata),
    .wstrb      (wstrb),
    .wvalid     (wvalid),
    .wready     (wready),
    .bresp      (bresp),
    .bvalid     (bvalid),
    .bready     (bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  logic rst_q;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst_n;
  end

  // Current transaction as seen by the requester (written only by main).
  bit          exp_wr;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;
  logic [3:0]  exp_mask;
  logic [2:0]  exp_f3;
  logic [1:0]  exp_off, exp_rresp, exp_bresp;
  int          exp_lat, req_cyc;
  int          ar_dly, r_dly, aw_dly, w_dly, b_dly;
  bit          dir_on;
  logic [31:0] dir_r, dir_ld;
  logic        dir_err;
  int          dir_lat;
  int          accepted = 0;

  // Checker-owned bookkeeping.
  int          completed = 0;
  int          done_count = 0;
  int          wait_cyc = 0;
  int          ar_n = 0, aw_n = 0, w_n = 0;
  bit          in_fl;
  logic [31:0] last_r, last_ld;
  bit          p_arv, p_arr, p_awv, p_awr, p_wv, p_wr;

  function automatic logic [31:0] model_ld(input logic [31:0] raw, input logic [1:0] off,
                                           input logic [2:0] f3);
    logic [31:0] w;
    byte         sb;
    shortint     sh;
    w  = raw >> (8 * off);
    sb = byte'(w[7:0]);
    sh = shortint'(w[15:0]);
    case (f3)
      3'd0:    return int'(sb);
      3'd4:    return w & 32'h0000_00FF;
      3'd1:    return int'(sh);
      3'd5:    return w & 32'h0000_FFFF;
      3'd2:    return w;
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
  endtask

  // Slave: each ready/valid rises after its programmed number of waiting cycles.
  int ar_c = 0, r_c = 0, aw_c = 0, w_c = 0, b_c = 0;
  always @(posedge clk) begin
    #2;
    if (!rst_q) begin
      arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
      ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
      rdata = 0; rresp = 0; bresp = 0;
    end else begin
      if (arvalid) begin arready = (ar_c >= ar_dly); ar_c++; end
      else begin arready = 0; ar_c = 0; end
      if (awvalid) begin awready = (aw_c >= aw_dly); aw_c++; end
      else begin awready = 0; aw_c = 0; end
      if (wvalid) begin wready = (w_c >= w_dly); w_c++; end
      else begin wready = 0; w_c = 0; end
      if (rready) begin
        rvalid = (r_c >= r_dly); r_c++;
        rdata  = rvalid ? exp_rdata : $urandom;
        rresp  = rvalid ? exp_rresp : 2'($urandom);
      end else begin
        rvalid = 0; r_c = 0; rdata = $urandom; rresp = 2'($urandom);
      end
      if (bready) begin
        bvalid = (b_c >= b_dly); b_c++;
        bresp  = bvalid ? exp_bresp : 2'($urandom);
      end else begin
        bvalid = 0; b_c = 0; bresp = 2'($urandom);
      end
    end
  end

  // Compare process: every cycle, DUT outputs against the transaction model.
  always @(negedge clk) begin
    if (!rst_q) begin
      chk("reset_ctl", {busy, done, bus_err, arvalid, rready, awvalid, wvalid, bready}, 64'h0);
      chk("reset_rd", {mem_2_r, ld_data}, 64'h0);
      chk("reset_addr", {araddr, awaddr}, 64'h0);
      chk("reset_wr", {wstrb, wdata}, 64'h0);
      completed = accepted;
      last_r = 0; last_ld = 0; wait_cyc = 0;
      ar_n = 0; aw_n = 0; w_n = 0;
      p_arv = 0; p_arr = 0; p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0;
    end else begin
      in_fl = (accepted != completed);
      if (done) begin
        chk("done_expected", 64'(in_fl), 64'h1);
        if (in_fl) begin
          if (exp_wr) begin
            chk("wr_err", bus_err, exp_bresp != 0);
            chk("wr_handshakes", {8'(ar_n), 8'(aw_n), 8'(w_n)}, 24'h000101);
          end else begin
            last_r  = exp_rdata;
            last_ld = model_ld(exp_rdata, exp_off, exp_f3);
            chk("rd_err", bus_err, exp_rresp != 0);
            chk("rd_handshakes", {8'(ar_n), 8'(aw_n), 8'(w_n)}, 24'h010000);
          end
          chk("latency", 64'(cyc - req_cyc), 64'(exp_lat));
          if (dir_on) begin
            chk("dir_latency", 64'(cyc - req_cyc), 64'(dir_lat));
            chk("dir_err", bus_err, dir_err);
            if (!exp_wr) begin
              chk("dir_raw", mem_2_r, dir_r);
              chk("dir_ld", ld_data, dir_ld);
            end
          end
          completed++;
          in_fl = 0;
        end
        ar_n = 0; aw_n = 0; w_n = 0; wait_cyc = 0;
        done_count++;
      end else begin
        chk("bus_err_low", bus_err, 1'b0);
        if (in_fl) begin
          wait_cyc++;
          if (wait_cyc > 100) begin
            chk("done_timeout", 64'(done), 64'h1);
            completed++; done_count++; wait_cyc = 0; in_fl = 0;
          end
        end
      end
      chk("busy", busy, in_fl);
      chk("mem_2_r_hold", mem_2_r, last_r);
      chk("ld_data_hold", ld_data, last_ld);
      if (arvalid) chk("ar_payload", {in_fl, exp_wr, araddr}, {1'b1, 1'b0, exp_addr});
      if (awvalid) chk("aw_payload", {in_fl, exp_wr, awaddr}, {1'b1, 1'b1, exp_addr});
      if (wvalid)  chk("w_payload", {in_fl, exp_wr, wstrb, wdata}, {1'b1, 1'b1, exp_mask, exp_wdata});
      if (p_arv && !p_arr) chk("arvalid_stable", arvalid, 1'b1);
      if (p_awv && !p_awr) chk("awvalid_stable", awvalid, 1'b1);
      if (p_wv && !p_wr)   chk("wvalid_stable", wvalid, 1'b1);
      if (arvalid && arready) ar_n++;
      if (awvalid && awready) aw_n++;
      if (wvalid && wready)   w_n++;
      p_arv = arvalid; p_arr = arready;
      p_awv = awvalid; p_awr = awready;
      p_wv  = wvalid;  p_wr  = wready;
    end
  end

  // Issue one request; returns on the edge just after its done cycle.
  task automatic do_txn(input bit wr, input bit both, input logic [31:0] addr, wd,
                        input logic [3:0] mask, input logic [2:0] f3, input logic [1:0] off,
                        input logic [31:0] rd, input logic [1:0] rr, br,
                        input int ard, rdd, awd, wdd, bdd,
                        input bit dir, input logic [31:0] d_r, d_ld, input logic d_err,
                        input int d_lat);
    int snap;
    int n;
    #1;
    exp_wr = wr; exp_addr = addr; exp_wdata = wd; exp_mask = mask;
    exp_f3 = f3; exp_off = off; exp_rdata = rd; exp_rresp = rr; exp_bresp = br;
    ar_dly = ard; r_dly = rdd; aw_dly = awd; w_dly = wdd; b_dly = bdd;
    exp_lat = wr ? 3 + ((awd > wdd) ? awd : wdd) + bdd : 3 + ard + rdd;
    dir_on = dir; dir_r = d_r; dir_ld = d_ld; dir_err = d_err; dir_lat = d_lat;
    mem_2_addr = addr; mem_2_w = wd; mem_2_mask = mask; funct3 = f3; byte_off = off;
    mem_2_w_en = wr; mem_2_r_en = !wr || both;
    req_cyc = cyc;
    snap = done_count;
    @(posedge clk);
    #1;
    mem_2_w_en = 0; mem_2_r_en = 0;
    mem_2_addr = $urandom; mem_2_w = $urandom; mem_2_mask = 4'($urandom);
    funct3 = 3'($urandom); byte_off = 2'($urandom);
    accepted++;
    n = 0;
    while (done_count == snap && n < 150) begin
      @(posedge clk);
      n++;
    end
  endtask

  logic [2:0] f3_tab [5];

  initial begin
    f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    rst_n = 0; mem_2_r_en = 1; mem_2_w_en = 0;
    mem_2_addr = 32'h8000_0000; mem_2_w = 0; mem_2_mask = 0; funct3 = 0; byte_off = 0;
    ar_dly = 0; r_dly = 0; aw_dly = 0; w_dly = 0; b_dly = 0;
    exp_wr = 0; exp_addr = 0; exp_wdata = 0; exp_mask = 0; exp_f3 = 0; exp_off = 0;
    exp_rdata = 0; exp_rresp = 0; exp_bresp = 0; exp_lat = 0; req_cyc = 0;
    dir_on = 0; dir_r = 0; dir_ld = 0; dir_err = 0; dir_lat = 0;
    repeat (2) @(posedge clk);
    #1;
    mem_2_r_en = 0; rst_n = 1;
    repeat (2) @(posedge clk);

    // lb, zero-wait slave
    do_txn(0, 0, 32'h8000_0004, 32'h0, 4'h0, 3'b000, 2'd2, 32'h12F4_5678, 2'b00, 2'b00,
           0, 0, 0, 0, 0, 1, 32'h12F4_5678, 32'hFFFF_FFF4, 1'b0, 3);
    repeat (2) @(posedge clk);
    // lhu with AR and R wait states
    do_txn(0, 0, 32'h8000_0010, 32'h0, 4'h0, 3'b101, 2'd2, 32'h8001_ABCD, 2'b00, 2'b00,
           2, 3, 0, 0, 0, 1, 32'h8001_ABCD, 32'h0000_8001, 1'b0, 8);
    repeat (2) @(posedge clk);
    // store: W first, AW two cycles later, one-cycle B wait
    do_txn(1, 0, 32'h8000_0020, 32'h0000_AB00, 4'b0010, 3'b000, 2'd1, 32'h0, 2'b00, 2'b00,
           0, 0, 2, 0, 1, 1, 32'h0, 32'h0, 1'b0, 6);
    repeat (2) @(posedge clk);
    // error write response
    do_txn(1, 0, 32'h8000_0024, 32'hDEAD_BEEF, 4'b1111, 3'b000, 2'd0, 32'h0, 2'b00, 2'b10,
           0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 1'b1, 3);
    // both enables: write must win
    do_txn(1, 1, 32'h8000_0028, 32'h0102_0304, 4'b0011, 3'b010, 2'd0, 32'h0, 2'b00, 2'b00,
           1, 0, 0, 1, 0, 1, 32'h0, 32'h0, 1'b0, 4);
    // back-to-back load then store
    do_txn(0, 0, 32'h8000_0030, 32'h0, 4'h0, 3'b010, 2'd0, 32'hCAFE_F00D, 2'b11, 2'b00,
           0, 0, 0, 0, 0, 1, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1, 3);
    do_txn(1, 0, 32'h8000_0034, 32'h5555_AAAA, 4'b1100, 3'b000, 2'd0, 32'h0, 2'b00, 2'b00,
           0, 0, 1, 2, 0, 1, 32'h0, 32'h0, 1'b0, 5);

    // read aborted by reset: no done may follow
    #1;
    exp_wr = 0; exp_addr = 32'h8000_0040; exp_rdata = 32'h1111_2222; exp_rresp = 0;
    exp_f3 = 3'd2; exp_off = 0; ar_dly = 6; r_dly = 0; dir_on = 0;
    mem_2_addr = 32'h8000_0040; funct3 = 3'd2; byte_off = 0; mem_2_r_en = 1;
    req_cyc = cyc;
    @(posedge clk);
    #1;
    mem_2_r_en = 0; accepted++;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    repeat (10) @(posedge clk);

    for (int i = 0; i < 120; i++) begin
      bit          wr;
      logic [2:0]  f3;
      wr = 1'($urandom);
      f3 = ($urandom_range(0, 4) != 0) ? f3_tab[$urandom_range(0, 4)] : 3'($urandom);
      do_txn(wr, ($urandom_range(0, 3) == 0), $urandom & 32'hFFFF_FFFC, $urandom,
             4'($urandom), f3, 2'($urandom), $urandom, 2'($urandom), 2'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3), 0, 32'h0, 32'h0, 1'b0, 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lsu_bus_if.md
Name: lsu_bus_if

Overview:
- Registered bridge between the memory-access stage's word-aligned request outputs and an AXI4-Lite-style data bus (separate read and write channels).
- Captures one load or store request and runs the bus handshakes.
- Stalls the core while the access is outstanding.
- Returns the raw read word plus a load value that is shifted by the byte offset and sign- or zero-extended according to funct3.

Parameters:
- ISA_WIDTH, 32, address/data width
- MEM_MASK_WIDTH, 4, byte-strobe width (ISA_WIDTH/8)
- FUNCT3_WIDTH, 3, load/store funct3 width

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- funct3  in  FUNCT3_WIDTH  load type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
- byte_off  in  2  unaligned address bits [1:0]
- mem_2_addr  in  ISA_WIDTH  word-aligned address
- mem_2_w  in  ISA_WIDTH  lane-shifted store data
- mem_2_mask  in  MEM_MASK_WIDTH  lane-shifted byte strobes
- mem_2_r_en  in  1  load request
- mem_2_w_en  in  1  store request
- mem_2_r  out  ISA_WIDTH  raw read word
- ld_data  out  ISA_WIDTH  aligned, extended load result
- busy  out  1  core stall
- done  out  1  one-cycle completion pulse
- bus_err  out  1  nonzero response, valid with done
- araddr  out  ISA_WIDTH; arvalid  out  1; arready  in  1
- rdata  in  ISA_WIDTH; rresp  in  2; rvalid  in  1; rready  out  1
- awaddr  out  ISA_WIDTH; awvalid  out  1; awready  in  1
- wdata  out  ISA_WIDTH; wstrb  out  MEM_MASK_WIDTH; wvalid  out  1; wready  in  1
- bresp  in  2; bvalid  in  1; bready  out  1

Behaviour:
- Clocking and reset:
  - All state changes on posedge clk.
  - The following are 0 while rst_n=0 and on the first cycle after release: all outputs and all registers; state=IDLE.
  - Reset mid-transaction abandons it: no done pulse, valids drop the next edge.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- IDLE:
  - mem_2_w_en=1 → latch addr, data, mask; go to WR_REQ. Store wins if both enables are high.
  - else mem_2_r_en=1 → latch addr, funct3, byte_off; go to RD_ADDR.
  - busy stays 0 in IDLE. It is registered and rises the cycle after acceptance.
  - The requester must deassert enables once done is seen. An enable held high in the cycle after done starts a new access.
- RD_ADDR:
  - arvalid=1, araddr=latched addr.
  - On arready go to RD_DATA; arvalid drops next cycle.
- RD_DATA:
  - rready=1.
  - On rvalid, at the next edge: mem_2_r←rdata; ld_data←extended value; bus_err←(rresp!=0); done=1 for one cycle; busy=0; state=IDLE.
  - mem_2_r and ld_data hold until the next read completes.
- WR_REQ:
  - awvalid and wvalid both asserted.
  - Each drops independently after its own ready handshake. The AW and W handshakes may complete in either order or in the same cycle.
  - Go to WR_RESP only when both handshakes have completed (tracked by two sticky flags).
- WR_RESP:
  - bready=1.
  - On bvalid: done pulse, bus_err←(bresp!=0), busy=0, state=IDLE.
- Valid/ready rules: once asserted, a valid and its payload stay stable until the handshake.
- Latency: minimum 3 cycles from request to done with zero-wait slave (accept edge, AR edge, R edge). Writes take the same 3 cycles minimum when AW and W complete together.
- Load extension:
  - sh = byte_off*8; w = raw >> sh.
  - lb: sign-extend w[7:0]; lbu: zero-extend w[7:0].
  - lh: sign-extend w[15:0]; lhu: zero-extend w[15:0].
  - lw: w. Other funct3 values give 0.
  - Misaligned halfword/word is not checked; the shifted value is used as-is.
- bus_err is valid only in the done cycle and is 0 otherwise.

Test Plan:
- Reset: rst_n=0 for 2 cycles while arvalid would assert → all outputs 0, state IDLE; an in-flight read aborted by reset gives no done.
- lb sign-extension: read addr 0x80000004, byte_off=2, funct3=000; rdata=0x12F45678 with zero-wait slave → done exactly 3 cycles after the request; mem_2_r=0x12F45678; ld_data=0xFFFFFFF4.
- lhu with wait states: byte_off=2, funct3=101, rdata=0x8001ABCD; arready delayed 2 cycles, rvalid delayed 3 → ld_data=0x00008001; busy high throughout; done only once.
- Store with AW/W skew: mem_2_w=0x0000AB00, mask=0010; wready in cycle 1, awready in cycle 3, bvalid in cycle 5 → wvalid drops after cycle 1 and awvalid after cycle 3; wstrb=0010; single done; bus_err=0.
- Error response and enable collision: bresp=2'b10 → bus_err=1 in the done cycle only. r_en=w_en=1 together → write path taken, arvalid never asserted.
- Back-to-back: a load, then a store with its enable asserted in the cycle right after done → both complete, in order, with no lost or duplicated handshakes.
